// File: rtl/demux_stream_if.sv
// Stream-side bundle of the 1:2 demux: one valid/ready input, two valid/ready outputs
// and the per-channel occupancy levels.
interface demux_stream_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             e;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [LW-1:0]    lvl0;
  logic [LW-1:0]    lvl1;

  modport master (
    output in_data, in_valid, e, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, lvl0, lvl1
  );

  modport slave (
    input  in_data, in_valid, e, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, lvl0, lvl1
  );
endinterface

// File: rtl/demux_fifo.sv
// Per-channel registered FIFO; head word reads zero while empty, level tracks occupancy.
module demux_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   lvl
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      lvl_q, lvl_d;

  assign full      = (lvl_q == (PW+1)'(DEPTH));
  assign empty     = (lvl_q == '0);
  assign lvl       = lvl_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + (PW+1)'(1);
      2'b01:   lvl_d = lvl_q - (PW+1)'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
endmodule

// File: rtl/demux_stream.sv
// 1:2 stream demultiplexer: e=1 routes to channel 0, e=0 to channel 1, each channel
// buffered by its own FIFO so one stalled consumer never blocks the other.
module demux_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_stream_if.slave        bus
);
  logic             in_ready;
  logic             push0, push1;
  logic             pop0, pop1;
  logic             full0, full1;
  logic             empty0, empty1;
  logic [WIDTH-1:0] head0, head1;
  logic [$clog2(DEPTH):0] lvl0, lvl1;

  // Ready looks only at the select and registered fullness, never at in_valid.
  assign in_ready = bus.e ? !full0 : !full1;
  assign push0    = bus.in_valid && in_ready &&  bus.e;
  assign push1    = bus.in_valid && in_ready && !bus.e;
  assign pop0     = !empty0 && bus.out0_ready;
  assign pop1     = !empty1 && bus.out1_ready;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (bus.in_data),
    .pop       (pop0),
    .head_data (head0),
    .full      (full0),
    .empty     (empty0),
    .lvl       (lvl0)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (bus.in_data),
    .pop       (pop1),
    .head_data (head1),
    .full      (full1),
    .empty     (empty1),
    .lvl       (lvl1)
  );

  assign bus.in_ready   = in_ready;
  assign bus.out0_data  = head0;
  assign bus.out0_valid = !empty0;
  assign bus.out1_data  = head1;
  assign bus.out1_valid = !empty1;
  assign bus.lvl0       = lvl0;
  assign bus.lvl1       = lvl1;
endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed scenarios plus a randomized stream
// compared against per-channel queue reference model.
module tb_demux_stream;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_stream_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();
  demux_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [WIDTH-1:0] q0[$], q1[$];
  logic [WIDTH-1:0] log0[$], log1[$];
  int tests_run = 0;
  int fails = 0;

  // One clock of the reference model: channel queues follow the accept/pop rules,
  // and observed DUT output handshakes are logged for order checks.
  task automatic cycle();
    logic             sel, acc, p0, p1;
    logic [WIDTH-1:0] d;
    sel = bus.e;
    d   = bus.in_data;
    acc = bus.in_valid && (sel ? (q0.size() < DEPTH) : (q1.size() < DEPTH));
    p0  = bus.out0_ready && (q0.size() > 0);
    p1  = bus.out1_ready && (q1.size() > 0);
    if (bus.out0_valid === 1'b1 && bus.out0_ready) log0.push_back(bus.out0_data);
    if (bus.out1_valid === 1'b1 && bus.out1_ready) log1.push_back(bus.out1_data);
    @(posedge clk);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (acc) begin
      if (sel) q0.push_back(d);
      else     q1.push_back(d);
    end
    #1;
  endtask

  task automatic drain();
    bus.in_valid   = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && (q0.size() != 0 || q1.size() != 0); i++) cycle();
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    log0.delete();
    log1.delete();
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0 || bus.lvl0 !== LW'(0) || bus.lvl1 !== LW'(0))
      begin fails++; $display("FAIL reset_idle: v0=%b v1=%b lvl0=%0d lvl1=%0d want 0", bus.out0_valid, bus.out1_valid, bus.lvl0, bus.lvl1); end
    tests_run++;
    if (bus.out0_data !== 8'h00 || bus.out1_data !== 8'h00)
      begin fails++; $display("FAIL reset_data: d0=%h d1=%h want 00", bus.out0_data, bus.out1_data); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    bus.e = 1'b1; bus.in_valid = 1'b1;
    bus.in_data = 8'hC1; cycle();
    bus.in_data = 8'hC2; cycle();
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.lvl0 !== LW'(2)) begin fails++; $display("FAIL prefill_lvl0: got %0d want 2", bus.lvl0); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out0_valid !== 1'b0 || bus.lvl0 !== LW'(0) || bus.out0_data !== 8'h00)
      begin fails++; $display("FAIL async_reset: v0=%b lvl0=%0d d0=%h want 0/0/00", bus.out0_valid, bus.lvl0, bus.out0_data); end
    q0.delete(); q1.delete(); log0.delete(); log1.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    bus.e = 1'b1; bus.in_data = 8'h11; bus.in_valid = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out0_valid !== 1'b0)
      begin fails++; $display("FAIL post_reset_pre: rdy=%b v0=%b want 1/0", bus.in_ready, bus.out0_valid); end
    cycle();
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'h11 || bus.lvl0 !== LW'(1))
      begin fails++; $display("FAIL post_reset_word: v0=%b d0=%h lvl0=%0d want 1/11/1", bus.out0_valid, bus.out0_data, bus.lvl0); end
    drain();
  endtask

  task automatic test_routing();
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    bus.in_valid = 1'b1; bus.e = 1'b1; bus.in_data = 8'hA5;
    cycle();
    tests_run++;
    if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'hA5 || bus.out1_valid !== 1'b0)
      begin fails++; $display("FAIL route_ch0: v0=%b d0=%h v1=%b want 1/a5/0", bus.out0_valid, bus.out0_data, bus.out1_valid); end
    bus.e = 1'b0; bus.in_data = 8'h5A;
    cycle();
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.out1_valid !== 1'b1 || bus.out1_data !== 8'h5A || bus.out0_valid !== 1'b0)
      begin fails++; $display("FAIL route_ch1: v1=%b d1=%h v0=%b want 1/5a/0", bus.out1_valid, bus.out1_data, bus.out0_valid); end
    tests_run++;
    if (log0.size() != 1 || log0[0] !== 8'hA5)
      begin fails++; $display("FAIL route_pop0: n=%0d want one word a5", log0.size()); end
    drain();
  endtask

  task automatic test_backpressure();
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    bus.in_valid = 1'b1; bus.e = 1'b1;
    bus.in_data = 8'h01; cycle();
    bus.in_data = 8'h02; cycle();
    bus.in_data = 8'h03;
    #1;
    tests_run++;
    if (bus.lvl0 !== LW'(2) || bus.in_ready !== 1'b0)
      begin fails++; $display("FAIL bp_full: lvl0=%0d rdy=%b want 2/0", bus.lvl0, bus.in_ready); end
    bus.e = 1'b0;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_other_ready: got %b want 1", bus.in_ready); end
    cycle();
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.out1_data !== 8'h03 || bus.lvl1 !== LW'(1) || bus.lvl0 !== LW'(2) || bus.out0_data !== 8'h01)
      begin fails++; $display("FAIL bp_route: d1=%h lvl1=%0d lvl0=%0d d0=%h want 03/1/2/01", bus.out1_data, bus.lvl1, bus.lvl0, bus.out0_data); end
    drain();
  endtask

  task automatic test_full_pop();
    bus.out0_ready = 1'b0; bus.in_valid = 1'b1; bus.e = 1'b1;
    bus.in_data = 8'h01; cycle();
    bus.in_data = 8'h02; cycle();
    log0.delete();
    bus.out0_ready = 1'b1; bus.in_data = 8'h03;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_pop_ready: got %b want 0", bus.in_ready); end
    cycle();
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out0_data !== 8'h02 || bus.lvl0 !== LW'(1))
      begin fails++; $display("FAIL full_pop_refill: rdy=%b d0=%h lvl0=%0d want 1/02/1", bus.in_ready, bus.out0_data, bus.lvl0); end
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    tests_run++;
    if (log0.size() != 3 || log0[0] !== 8'h01 || log0[1] !== 8'h02 || log0[2] !== 8'h03)
      begin fails++; $display("FAIL full_pop_order: n=%0d want 01,02,03", log0.size()); end
    drain();
  endtask

  task automatic test_push_pop();
    bus.out1_ready = 1'b0; bus.in_valid = 1'b1; bus.e = 1'b0; bus.in_data = 8'h10;
    cycle();
    tests_run++;
    if (bus.lvl1 !== LW'(1) || bus.out1_data !== 8'h10)
      begin fails++; $display("FAIL pp_prefill: lvl1=%0d d1=%h want 1/10", bus.lvl1, bus.out1_data); end
    bus.in_data = 8'h20; bus.out1_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0; bus.out1_ready = 1'b0;
    tests_run++;
    if (bus.lvl1 !== LW'(1) || bus.out1_data !== 8'h20)
      begin fails++; $display("FAIL pp_same_cycle: lvl1=%0d d1=%h want 1/20", bus.lvl1, bus.out1_data); end
    drain();
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] exp0[$], exp1[$];
    int idx = 0;
    int cyc = 0;
    logic exp_rdy;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) exp0.push_back(WIDTH'(i));
      else            exp1.push_back(WIDTH'(i));
    end
    log0.delete(); log1.delete();
    while ((idx < 16 || q0.size() != 0 || q1.size() != 0) && cyc < 400) begin
      bus.in_valid   = (idx < 16);
      bus.in_data    = WIDTH'(idx);
      bus.e          = (idx % 2 == 0);
      bus.out0_ready = 1'($urandom_range(0, 1));
      bus.out1_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = bus.e ? (q0.size() < DEPTH) : (q1.size() < DEPTH);
      tests_run++;
      if (bus.in_ready !== exp_rdy) begin fails++; $display("FAIL wrap_ready: cyc=%0d got %b want %b", cyc, bus.in_ready, exp_rdy); end
      cycle();
      if (bus.in_valid && exp_rdy) idx++;
      tests_run++;
      if (bus.lvl0 !== LW'(q0.size()) || bus.out0_valid !== (q0.size() != 0) ||
          bus.out0_data !== (q0.size() != 0 ? q0[0] : 8'h00))
        begin fails++; $display("FAIL wrap_ch0: cyc=%0d lvl=%0d v=%b d=%h want lvl %0d", cyc, bus.lvl0, bus.out0_valid, bus.out0_data, q0.size()); end
      tests_run++;
      if (bus.lvl1 !== LW'(q1.size()) || bus.out1_valid !== (q1.size() != 0) ||
          bus.out1_data !== (q1.size() != 0 ? q1[0] : 8'h00))
        begin fails++; $display("FAIL wrap_ch1: cyc=%0d lvl=%0d v=%b d=%h want lvl %0d", cyc, bus.lvl1, bus.out1_valid, bus.out1_data, q1.size()); end
      tests_run++;
      if (bus.lvl0 > LW'(DEPTH) || bus.lvl1 > LW'(DEPTH))
        begin fails++; $display("FAIL wrap_level_bound: lvl0=%0d lvl1=%0d max %0d", bus.lvl0, bus.lvl1, DEPTH); end
      cyc++;
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (idx < 16 || q0.size() != 0 || q1.size() != 0)
      begin fails++; $display("FAIL wrap_timeout: sent %0d of 16 after %0d cycles", idx, cyc); end
    tests_run++;
    if (log0.size() != exp0.size()) begin fails++; $display("FAIL wrap_count0: got %0d want %0d", log0.size(), exp0.size()); end
    tests_run++;
    if (log1.size() != exp1.size()) begin fails++; $display("FAIL wrap_count1: got %0d want %0d", log1.size(), exp1.size()); end
    for (int i = 0; i < exp0.size() && i < log0.size(); i++) begin
      tests_run++;
      if (log0[i] !== exp0[i]) begin fails++; $display("FAIL wrap_order0[%0d]: got %h want %h", i, log0[i], exp0[i]); end
    end
    for (int i = 0; i < exp1.size() && i < log1.size(); i++) begin
      tests_run++;
      if (log1[i] !== exp1[i]) begin fails++; $display("FAIL wrap_order1[%0d]: got %h want %h", i, log1[i], exp1[i]); end
    end
    drain();
  endtask

  initial begin
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.e          = 1'b0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    test_reset();
    test_routing();
    test_backpressure();
    test_full_pop();
    test_push_pop();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
